// File: rtl/riscv_pkg.sv
// Shared RV64 datapath definitions: opcodes, sequencer state encoding,
// PC mux select values and the legal-opcode check used at DECODE.
package riscv_pkg;

  localparam int unsigned OPCODE_W = 7;

  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_ARITH  = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

  localparam logic PC_SEL_SEQ = 1'b0;
  localparam logic PC_SEL_BR  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_FAULT   = 3'd6
  } seq_state_e;

  // True for the four opcode classes the sequencer knows how to run.
  function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_ARITH) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait timer shared by the FETCH and MEM waits.
// Ports: clk, rst_n (async active-low), clear (zero the count),
//        count (one more cycle waited), expired (count reached TIMEOUT-1).
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] wait_cnt;

  // Count waited cycles; clear has priority so a fresh wait always starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (count) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign expired = (wait_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle sequencer for the RV64 datapath. Drives PC/IR/data-memory/
// register-file strobes per phase from state plus control_unit decode.
// Ports: clk, rst_n, start, halt, opcode, ctrl_mem_r/w, ctrl_reg_w,
//        ctrl_branch, alu_zero, imem_ready, dmem_ready (inputs);
//        imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, busy,
//        fault (combinational from state + inputs), retired (counter).
module multicycle_sequencer
  import riscv_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic [6:0]       opcode,
  input  logic             ctrl_mem_r,
  input  logic             ctrl_mem_w,
  input  logic             ctrl_reg_w,
  input  logic             ctrl_branch,
  input  logic             alu_zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  seq_state_e state_q, state_d;
  logic       retire_c;
  logic       wait_state_c;
  logic       wait_ready_c;
  logic       timer_clear_c;
  logic       timer_count_c;
  logic       timer_expired_c;

  assign wait_state_c  = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign wait_ready_c  = (state_q == ST_FETCH) ? imem_ready : dmem_ready;
  // Any state change (entry to FETCH/MEM included) restarts the wait count.
  assign timer_clear_c = (state_d != state_q);
  assign timer_count_c = wait_state_c && !wait_ready_c;

  mem_wait_timer #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear_c),
    .count   (timer_count_c),
    .expired (timer_expired_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Retired-instruction counter, wraps modulo 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
    end else if (retire_c) begin
      retired <= retired + CNT_W'(1);
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_SEL_SEQ;
    retire_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (timer_expired_c) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        state_d = is_legal_op(opcode) ? ST_EXECUTE : ST_FAULT;
      end
      ST_EXECUTE: begin
        if (ctrl_branch) begin
          pc_we    = 1'b1;
          pc_sel   = alu_zero ? PC_SEL_BR : PC_SEL_SEQ;
          retire_c = 1'b1;
        end else if (ctrl_mem_r || ctrl_mem_w) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = ctrl_mem_w;
        if (dmem_ready) begin
          if (ctrl_mem_r) begin
            state_d = ST_WB;
          end else begin
            pc_we    = 1'b1;
            retire_c = 1'b1;
          end
        end else if (timer_expired_c) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB: begin
        rf_we    = ctrl_reg_w;
        pc_we    = 1'b1;
        retire_c = 1'b1;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase

    // Instruction boundary: halt is only honoured here.
    if (retire_c) state_d = halt ? ST_IDLE : ST_FETCH;
  end

  assign busy  = (state_q != ST_IDLE) && (state_q != ST_FAULT);
  assign fault = (state_q == ST_FAULT);

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle FSM that sequences the RV64 datapath around the combinational control_unit.
- Takes the current IR opcode and the control_unit decode outputs (ctrl_mem_r/w, ctrl_reg_w, ctrl_branch) and produces per-phase strobes for PC, IR, data memory and register file.
- Handles instruction- and data-memory ready handshakes with a wait timeout, and counts retired instructions.
- Sits between the instruction/data memories and the datapath in the CPU top level; it does not instantiate control_unit.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- MEM_TIMEOUT, 16, maximum cycles waited for imem_ready/dmem_ready before fault (must be >= 1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  leave IDLE and begin fetching; level, sampled in IDLE only.
- halt  in  1  return to IDLE at the next instruction boundary.
- opcode  in  7  IR[6:0].
- ctrl_mem_r  in  1  from control_unit.
- ctrl_mem_w  in  1  from control_unit.
- ctrl_reg_w  in  1  from control_unit.
- ctrl_branch  in  1  from control_unit.
- alu_zero  in  1  ALU zero flag, used for the BEQ decision.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- ir_we  out  1  IR load strobe.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (valid only with dmem_req).
- rf_we  out  1  register file write enable.
- pc_we  out  1  PC update strobe.
- pc_sel  out  1  0 = PC+4, 1 = branch target.
- busy  out  1  state not IDLE and not FAULT.
- fault  out  1  sticky fault indicator.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: state=IDLE, wait_cnt=0, retired=0. All strobes, busy and fault are 0 while rst_n is low.
- Outputs decode combinationally from state plus the listed inputs. Only state, wait_cnt and retired are registered.
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, FAULT.
- IDLE:
  - start=1 -> FETCH.
  - halt is ignored.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_we=1 in the same cycle -> DECODE.
- DECODE: single cycle.
  - Legal opcodes: 0000011 LOAD, 0100011 STORE, 0110011 ARITH, 1100011 BRANCH.
  - Any other opcode -> FAULT.
  - Otherwise -> EXECUTE.
- EXECUTE: single cycle; ALU evaluates.
  - ctrl_branch=1: pc_we=1, pc_sel=alu_zero, retire.
  - ctrl_mem_r or ctrl_mem_w: -> MEM.
  - Otherwise: -> WB.
- MEM:
  - dmem_req=1, dmem_we=ctrl_mem_w.
  - On dmem_ready, load (ctrl_mem_r) -> WB.
  - On dmem_ready, store: pc_we=1, pc_sel=0, retire.
- WB:
  - rf_we=ctrl_reg_w, pc_we=1, pc_sel=0, retire.
- Retire:
  - retired increments by 1, wrapping modulo 2^CNT_W.
  - Next state is IDLE if halt=1 in that cycle, else FETCH.
- Latency with zero-wait memories: ARITH 4 cycles, LOAD 5, STORE 4, BRANCH 3 (FETCH to retire inclusive).
- Wait timeout:
  - wait_cnt clears on every entry to FETCH/MEM.
  - It increments each FETCH/MEM cycle without ready.
  - If wait_cnt==MEM_TIMEOUT-1 and ready is still 0 -> FAULT.
  - Ready arriving in the MEM_TIMEOUT-th waiting cycle is accepted (ready wins).
- FAULT:
  - fault=1 and all strobes 0.
  - start and halt are ignored; exit only via rst_n.
  - retired holds its value.
- halt mid-instruction (in FETCH/DECODE/EXECUTE/MEM) has no effect until the retire cycle; halt need not be held after that.
- Reset asserted mid-operation (including during a pending memory wait) returns to IDLE immediately; the outstanding request is dropped.
- Strobes are mutually consistent: dmem_we never 1 without dmem_req; rf_we and pc_we only in retire-capable states.

Decomposition:
- Shared package riscv_pkg:
  - opcode constants (LOAD/STORE/ARITH/BRANCH);
  - the sequencer state enum with its 3-bit encoding;
  - the PC_SEL_SEQ=0 and PC_SEL_BR=1 constants.
- One sub-module, mem_wait_timer (clear, count, expired), used for both the FETCH and MEM waits.

Test Plan:
1. Reset, start=1, opcode=0110011 with ctrl_reg_w=1, both memories ready immediately:
   - ir_we in cycle 1;
   - rf_we=1 and pc_we=1 (pc_sel=0) in cycle 4;
   - retired=1.
2. LOAD (0000011, mem_r=1, reg_w=1), dmem_ready delayed 3 cycles:
   - dmem_req high 4 cycles with dmem_we=0;
   - rf_we in the following cycle;
   - total 8 cycles.
3. STORE (0100011), then BRANCH (1100011) with alu_zero=1:
   - store retires with dmem_we=1 and pc_sel=0, no rf_we;
   - branch asserts pc_we=1 with pc_sel=1 in its EXECUTE;
   - retired=2.
4. imem_ready held low for 16 cycles (MEM_TIMEOUT=16):
   - FAULT entered, fault=1, busy=0;
   - start toggles ignored;
   - repeat with ready in wait cycle 16 -> accepted, no fault.
5. Illegal opcode 1111111 at DECODE:
   - FAULT next cycle, no pc_we/rf_we;
   - rst_n pulse low mid-fault -> IDLE with all outputs 0 and retired=0.
6. halt=1 asserted during MEM of a store:
   - store completes and retires, then IDLE (busy=0);
   - with CNT_W=4, 16 retirements wrap retired to 0.
